parity_frame_receiver: RTL



---
 rtl/parity_frame_receiver_pkg.sv | 13 +
 rtl/parity_frame_receiver_if.sv | 27 ++
 rtl/parity_frame_receiver_parity_checker.sv | 10 +
 rtl/parity_frame_receiver.sv | 135 +++++++++++++
 4 files changed

// File: rtl/parity_frame_receiver_pkg.sv
// Shared constants for the even-parity serial frame receiver.
package parity_frame_receiver_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_DATA   = 2'd1;
    localparam logic [ST_W-1:0] ST_PARITY = 2'd2;
    localparam logic [ST_W-1:0] ST_STOP   = 2'd3;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/parity_frame_receiver_if.sv
// Line-sample, word handshake and error-report signals of the frame receiver.
interface parity_frame_receiver_if #(
    parameter int unsigned width  = 8,
    parameter int unsigned cwidth = 8
);
    logic              i_tick;
    logic              i_bit;
    logic              i_ready;
    logic              i_clear;
    logic [width-1:0]  o_data;
    logic              o_valid;
    logic              o_parity_error;
    logic              o_frame_error;
    logic              o_overrun;
    logic [cwidth-1:0] o_error_count;

    // Front end plus word consumer drive the inputs.
    modport master (
        output i_tick, i_bit, i_ready, i_clear,
        input  o_data, o_valid, o_parity_error, o_frame_error, o_overrun, o_error_count
    );

    modport slave (
        input  i_tick, i_bit, i_ready, i_clear,
        output o_data, o_valid, o_parity_error, o_frame_error, o_overrun, o_error_count
    );
endinterface

// File: rtl/parity_frame_receiver_parity_checker.sv
// Even parity check: error is high when data plus parity bit hold an odd number of ones.
module even_parity_checker #(
    parameter int unsigned width = 8
) (
    input  logic [width-1:0] data_i,
    input  logic             parity_i,
    output logic             error_c_o
);
    assign error_c_o = ^{data_i, parity_i};
endmodule

// File: rtl/parity_frame_receiver.sv
// Serial frame receiver: start/data/parity/stop sequencing, one-entry word buffer,
// and a saturating count of parity, framing and overrun events.
module parity_frame_receiver
    import parity_frame_receiver_pkg::*;
#(
    parameter int unsigned width  = 8,
    parameter int unsigned cwidth = 8
) (
    input  logic                    clk,
    input  logic                    rst_x,
    parity_frame_receiver_if.slave  bus
);
    localparam int unsigned     CNT_W   = $clog2(width + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width - 1);
    localparam logic [cwidth-1:0] ERR_MAX = '1;

    logic [ST_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [width-1:0]  shift_q, shift_d;
    logic              par_q, par_d;
    logic [width-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic [cwidth-1:0] errcnt_q, errcnt_d;

    logic [width:0]    shift_ext_c;
    logic              stop_tick_c;
    logic              stop_ok_c;
    logic              frame_bad_c;
    logic              consume_c;
    logic              overrun_c;
    logic              load_c;
    logic              event_c;
    logic              par_err_c;

    even_parity_checker #(.width(width)) u_parity (
        .data_i    (shift_q),
        .parity_i  (par_q),
        .error_c_o (par_err_c)
    );

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        stop_tick_c = 1'b0;
        shift_ext_c = {bus.i_bit, shift_q};

        // Frame sequencing advances only on line-sample strobes.
        if (bus.i_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_bit != LINE_IDLE) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
                ST_DATA: begin
                    shift_d = shift_ext_c[width:1];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = bus.i_bit;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    stop_tick_c = 1'b1;
                    state_d     = ST_IDLE;
                end
            endcase
        end

        stop_ok_c   = stop_tick_c && (bus.i_bit == LINE_IDLE);
        frame_bad_c = stop_tick_c && (bus.i_bit != LINE_IDLE);
        consume_c   = valid_q && bus.i_ready;
        overrun_c   = stop_ok_c && valid_q && !consume_c;
        load_c      = stop_ok_c && !overrun_c;
        // A parity error on a dropped word is already counted as the overrun.
        event_c     = frame_bad_c || overrun_c || (load_c && par_err_c);

        data_d  = load_c ? shift_q   : data_q;
        perr_d  = load_c ? par_err_c : perr_q;
        valid_d = load_c ? 1'b1 : (consume_c ? 1'b0 : valid_q);
        ferr_d  = frame_bad_c;
        ovr_d   = overrun_c;

        if (bus.i_clear) begin
            errcnt_d = cwidth'(event_c);
        end else if (event_c && (errcnt_q != ERR_MAX)) begin
            errcnt_d = errcnt_q + cwidth'(1);
        end else begin
            errcnt_d = errcnt_q;
        end
    end

    assign bus.o_data         = data_q;
    assign bus.o_valid        = valid_q;
    assign bus.o_parity_error = perr_q;
    assign bus.o_frame_error  = ferr_q;
    assign bus.o_overrun      = ovr_q;
    assign bus.o_error_count  = errcnt_q;

endmodule
